// File: rtl/matrix_dot_sequencer.sv
// Sequences a registered-product MAC core through an N-element dot product,
// fetching operands from two synchronous-read memories and returning the sum over valid/ready.
module matrix_dot_sequencer #(
    parameter int AW = 8,
    parameter int LW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] stride_b,
    output logic          busy,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_a_addr,
    output logic [AW-1:0] mem_b_addr,
    input  logic [DW-1:0] mem_a_rdata,
    input  logic [DW-1:0] mem_b_rdata,
    output logic [DW-1:0] core_a,
    output logic [DW-1:0] core_b,
    output logic          core_m_rst,
    input  logic [DW-1:0] core_acc,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data
);

    // Result handshake: the result transfers on any rising edge where
    // res_valid && res_ready; res_data is held stable while res_valid is high.

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] a_addr, b_addr, stride_q;
    logic [LW-1:0] remain;
    logic          first_q;
    logic          t1_valid, t1_first, t1_last;
    logic          t2_valid, t2_first, t2_last;
    logic          t3_valid, t3_last;
    logic          last_read;
    logic          capture;

    assign last_read = (state == ISSUE) && (remain == LW'(1));
    assign capture   = (state == DRAIN) && t3_valid && t3_last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = (len == '0) ? DONE : ISSUE;
            ISSUE: if (last_read) state_next = DRAIN;
            DRAIN: if (capture) state_next = DONE;
            DONE:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mem_rd_en = (state == ISSUE);
        res_valid = (state == DONE);
    end

    // Address generation, tag pipeline and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_addr   <= '0;
            b_addr   <= '0;
            stride_q <= '0;
            remain   <= '0;
            first_q  <= 1'b0;
            t1_valid <= 1'b0;
            t1_first <= 1'b0;
            t1_last  <= 1'b0;
            t2_valid <= 1'b0;
            t2_first <= 1'b0;
            t2_last  <= 1'b0;
            t3_valid <= 1'b0;
            t3_last  <= 1'b0;
            res_data <= '0;
        end else begin
            t1_valid <= mem_rd_en;
            t1_first <= mem_rd_en && first_q;
            t1_last  <= last_read;
            t2_valid <= t1_valid;
            t2_first <= t1_first;
            t2_last  <= t1_last;
            t3_valid <= t2_valid;
            t3_last  <= t2_last;

            if (state == IDLE && start) begin
                if (len == '0) begin
                    res_data <= '0;
                end else begin
                    a_addr   <= base_a;
                    b_addr   <= base_b;
                    stride_q <= stride_b;
                    remain   <= len;
                    first_q  <= 1'b1;
                end
            end

            // Running-sum stride keeps the B address path multiplier-free.
            if (state == ISSUE) begin
                a_addr  <= a_addr + AW'(1);
                b_addr  <= b_addr + stride_q;
                remain  <= remain - LW'(1);
                first_q <= 1'b0;
            end

            if (capture) res_data <= core_acc;
        end
    end

    assign mem_a_addr = a_addr;
    assign mem_b_addr = b_addr;

    // Idle operands are forced to zero so the core's accumulator stays put between jobs.
    assign core_a     = t1_valid ? mem_a_rdata : '0;
    assign core_b     = t1_valid ? mem_b_rdata : '0;
    assign core_m_rst = t2_valid && t2_first;

endmodule

// File: tb/tb_matrix_dot_sequencer.sv
// Bench for matrix_dot_sequencer: memory and MAC-core models around the DUT,
// directed plus randomized jobs checked against an arithmetic dot-product reference.
module tb_matrix_dot_sequencer;
    localparam int AW = 8;
    localparam int LW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic [AW-1:0] base_a, base_b, stride_b;
    logic          busy, mem_rd_en;
    logic [AW-1:0] mem_a_addr, mem_b_addr;
    logic [DW-1:0] mem_a_rdata, mem_b_rdata;
    logic [DW-1:0] core_a, core_b;
    logic          core_m_rst;
    logic [DW-1:0] core_acc;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] prod;
    logic [DW-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    matrix_dot_sequencer #(.AW(AW), .LW(LW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .base_a(base_a), .base_b(base_b), .stride_b(stride_b),
        .busy(busy), .mem_rd_en(mem_rd_en),
        .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
        .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata),
        .core_a(core_a), .core_b(core_b), .core_m_rst(core_m_rst),
        .core_acc(core_acc), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    // clock / environment models
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_a_rdata <= mem_a[mem_a_addr];
            mem_b_rdata <= mem_b[mem_b_addr];
        end
    end

    always @(posedge clk) begin
        prod     <= core_a * core_b;
        core_acc <= core_m_rst ? prod : core_acc + prod;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_dot(input int n, input int ba, input int bb, input int sb);
        logic [DW-1:0] s, x, y;
        s = '0;
        for (int i = 0; i < n; i++) begin
            x = mem_a[(ba + i) % 256];
            y = mem_b[(bb + i * sb) % 256];
            s = s + x * y;
        end
        return s;
    endfunction

    // One job from start to handshake; ends on the negedge after the handshake edge.
    task automatic run_job(input int n, input int ba, input int bb, input int sb,
                           input int hold, input bit pulse);
        int cyc;
        int exp_lat;
        logic [DW-1:0] exp_sum;
        exp_sum = ref_dot(n, ba, bb, sb);
        exp_q.push_back(exp_sum);
        exp_lat = (n == 0) ? 1 : n + 4;
        check("idle_before_start", {31'd0, busy}, 32'd0);
        start    = 1'b1;
        len      = LW'(n);
        base_a   = AW'(ba);
        base_b   = AW'(bb);
        stride_b = AW'(sb);
        @(negedge clk);
        cyc = 1;
        forever begin
            start     = 1'($urandom_range(0, 1));
            len       = LW'($urandom_range(0, 255));
            base_a    = AW'($urandom);
            base_b    = AW'($urandom);
            stride_b  = AW'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            check("busy", {31'd0, busy}, 32'd1);
            check("rd_en", {31'd0, mem_rd_en}, {31'd0, (cyc <= n)});
            check("m_rst", {31'd0, core_m_rst}, {31'd0, (n > 0 && cyc == 3)});
            if (cyc <= n) begin
                check("addr_a", {24'd0, mem_a_addr}, 32'((ba + cyc - 1) % 256));
                check("addr_b", {24'd0, mem_b_addr}, 32'((bb + (cyc - 1) * sb) % 256));
            end
            if (res_valid || cyc >= n + 12) break;
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            start     = pulse;
            len       = LW'($urandom_range(1, 255));
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_data", res_data, exp_sum);
            check("hold_busy", {31'd0, busy}, 32'd1);
            check("hold_no_rd", {31'd0, mem_rd_en}, 32'd0);
            @(negedge clk);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        check("res_valid", {31'd0, res_valid}, 32'd1);
        check("res_data", res_data, exp_q.pop_front());
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_after", {31'd0, busy}, 32'd0);
        check("valid_after", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        rst = 1'b1; start = 1'b0; len = '0; base_a = '0; base_b = '0; stride_b = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_m_rst", {31'd0, core_m_rst}, 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_core_a", core_a, 32'd0);
        check("rst_addr_b", {24'd0, mem_b_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic 70 job, then back-to-back 1x9
        for (int i = 0; i < 4; i++) begin
            mem_a[i]      = 32'(i + 1);
            mem_b[16 + i] = 32'(i + 5);
        end
        mem_a[100] = 32'd1;
        mem_b[101] = 32'd9;
        check("ref_70", ref_dot(4, 0, 16, 1), 32'd70);
        run_job(4, 0, 16, 1, 0, 1'b0);
        run_job(1, 100, 101, 0, 0, 1'b0);

        // B address wrap
        run_job(3, 40, 250, 4, 0, 1'b0);

        // stalled consumer with start pulses, then a new job
        run_job(5, 10, 20, 3, 6, 1'b1);
        run_job(2, 60, 70, 9, 1, 1'b1);

        // empty job and overflow wrap
        run_job(0, 0, 0, 0, 0, 1'b0);
        mem_a[200] = 32'h10000; mem_a[201] = 32'h10000;
        mem_b[210] = 32'h10000; mem_b[211] = 32'h10000;
        check("ref_wrap", ref_dot(2, 200, 210, 1), 32'd0);
        run_job(2, 200, 210, 1, 0, 1'b0);

        // reset in cycle 3 of an N=8 job
        start = 1'b1; len = 8'd8; base_a = 8'd30; base_b = 8'd90; stride_b = 8'd2;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("mid_rst_m_rst", {31'd0, core_m_rst}, 32'd0);
        check("mid_rst_core_a", core_a, 32'd0);
        check("mid_rst_core_b", core_b, 32'd0);
        check("mid_rst_addr_a", {24'd0, mem_a_addr}, 32'd0);
        check("mid_rst_addr_b", {24'd0, mem_b_addr}, 32'd0);
        check("mid_rst_data", res_data, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("mid_rst_no_valid", {31'd0, res_valid}, 32'd0);
            @(negedge clk);
        end
        mem_a[5] = 32'd3;
        mem_b[6] = 32'd7;
        run_job(1, 5, 6, 1, 0, 1'b0);

        // randomized jobs
        for (int j = 0; j < 12; j++) begin
            run_job($urandom_range(0, 12), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matrix_dot_sequencer.md
# matrix_dot_sequencer

Controller that sequences one multiply-accumulate core (registered product stage, then accumulator with a first-element reload strobe) through an N-element dot product. Operands come from two synchronous-read operand memories. The block:
- issues operand addresses, with unit stride on A and programmable stride on B (matrix row × column);
- aligns the core's accumulator-reload strobe with the first product;
- captures the final sum and returns it over a valid/ready result port.

## Interface
Parameters:
- AW, 8, operand memory address width
- LW, 8, length field width (max N = 2^LW − 1)
- DW, 32, data/accumulator width (matches core)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; accepted only in IDLE
- len  in  LW  element count N, sampled with start
- base_a  in  AW  first A address, sampled with start
- base_b  in  AW  first B address, sampled with start
- stride_b  in  AW  B address increment, sampled with start
- busy  out  1  high whenever state ≠ IDLE
- mem_rd_en  out  1  read strobe to both operand memories
- mem_a_addr  out  AW  A read address
- mem_b_addr  out  AW  B read address
- mem_a_rdata  in  DW  A data, valid the cycle after mem_rd_en
- mem_b_rdata  in  DW  B data, valid the cycle after mem_rd_en
- core_a  out  DW  multiplicand to core
- core_b  out  DW  multiplier to core
- core_m_rst  out  1  accumulator reload strobe to core
- core_acc  in  DW  core accumulator output
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  DW  dot-product result

## Operation
States and transitions:
- IDLE: waits for start. On start with N=0, go to DONE with res_data=0 and issue no reads. On start with N≥1, latch the job fields and go to ISSUE.
- ISSUE: one read per cycle for N cycles, with index i = 0..N−1.
  - mem_a_addr = base_a + i (mod 2^AW).
  - mem_b_addr = base_b + i·stride_b (mod 2^AW), formed by running-sum addition, no multiplier.
  - After the last read, go to DRAIN.
- DRAIN: waits for the tag pipeline to empty. Then captures core_acc into res_data and goes to DONE.
- DONE: holds res_valid=1 and res_data stable until res_ready=1, then returns to IDLE.

Tag pipeline (valid/first/last bits) follows each read:
- Stage 1 (read data cycle): core_a = mem_a_rdata and core_b = mem_b_rdata when the tag is valid. Otherwise both are 0, so the core accumulates zero and core_acc stays stable between jobs.
- Stage 2 (product cycle): core_m_rst = first tag. It is high for exactly one cycle per job.
- Stage 3 (accumulated cycle): last tag triggers capture of core_acc.

Other rules:
- Arithmetic is modulo 2^DW; overflow wraps silently.
- The sequencer never resets the core. Correctness comes from core_m_rst on the first element.
- start while busy is ignored; no queueing.
- res_ready while res_valid=0 is ignored.

## Timing
Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- mem_rd_en=1 in cycles 1..N; address index i in cycle i+1.
- core_a/core_b carry element i in cycle i+2.
- core_m_rst=1 in cycle 3 only.
- core_acc holds the complete sum in cycle N+3 and is captured at the end of that cycle.
- res_valid=1 from cycle N+4: latency is N+4 cycles from start to res_valid.
- N=0: res_valid=1 in cycle 1.
- Handshake completes on the edge where res_valid & res_ready. The state is IDLE in the next cycle, and start is accepted from that cycle on, giving a minimum gap of one cycle between jobs.
- Reset values and synchronous rst at any point, including mid-ISSUE or mid-DRAIN:
  - state = IDLE;
  - busy, mem_rd_en, core_m_rst, res_valid = 0;
  - core_a, core_b, res_data, mem_a_addr, mem_b_addr = 0;
  - tag pipeline cleared;
  - in-flight job discarded, with no partial result emitted.

## Test plan
- N=4, A=[1,2,3,4] at base_a=0, B=[5,6,7,8] at base_b=16, stride_b=1, res_ready=1 → res_data=70 with res_valid in cycle 8; core_m_rst high only in cycle 3.
- N=3, base_b=250, stride_b=4, AW=8 → B addresses 250, 254, 2 (wrap); sum matches a memory model.
- Two back-to-back jobs (sums 70, then 1×9=9), second start issued the cycle after handshake → second res_data=9, with no carryover from the first.
- res_ready held low for 6 cycles after res_valid, with start pulsed each of those cycles → res_data stable, busy=1, no reads issued, and the second job starts only after handshake.
- N=0 → no mem_rd_en, res_valid in cycle 1, res_data=0. Overflow case: N=2, A=B=[0x10000,0x10000] → res_data=0 (wrap).
- rst asserted in cycle 3 of an N=8 job → all outputs 0 next cycle, res_valid never rises. A following N=1 job (3×7) → 21.
